// File: rtl/uart_pkg.sv
// Shared UART16550 register map, bring-up sequencer states and bus request payload.
package uart_pkg;

   localparam logic [2:0] ADDR_DLL_THR = 3'd0;
   localparam logic [2:0] ADDR_DLM_IER = 3'd1;
   localparam logic [2:0] ADDR_FCR     = 3'd2;
   localparam logic [2:0] ADDR_LCR     = 3'd3;
   localparam logic [2:0] ADDR_LSR     = 3'd5;

   localparam int unsigned LCR_DLAB_BIT = 7;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_WR_LCR_D,
      ST_WR_DLL,
      ST_WR_DLM,
      ST_RD_DLL,
      ST_CHK_DLL,
      ST_RD_DLM,
      ST_CHK_DLM,
      ST_WR_LCR,
      ST_WR_FCR,
      ST_RD_LCR,
      ST_CHK_LCR,
      ST_DONE
   } cfg_state_e;

   typedef struct packed {
      logic       wr;
      logic       rd;
      logic [2:0] addr;
      logic [7:0] wdata;
   } bus_req_t;

   function automatic bus_req_t bus_write(logic [2:0] addr, logic [7:0] data);
      bus_req_t r;
      r.wr    = 1'b1;
      r.rd    = 1'b0;
      r.addr  = addr;
      r.wdata = data;
      return r;
   endfunction

   function automatic bus_req_t bus_read(logic [2:0] addr);
      bus_req_t r;
      r.wr    = 1'b0;
      r.rd    = 1'b1;
      r.addr  = addr;
      r.wdata = 8'h00;
      return r;
   endfunction

endpackage

// File: rtl/uart_cfg_seq.sv
// Register-bus initiator that programs divisor, frame format and FCR into regs_uart,
// with optional read-back verification of the divisor latch and LCR.
module uart_cfg_seq
   import uart_pkg::*;
#(
   parameter int unsigned RD_LAT = 1,
   parameter int unsigned VERIFY = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] divisor,
   input  logic [6:0]  lcr_fmt,
   input  logic [7:0]  fcr_val,
   input  logic [7:0]  rdata_i,
   output logic        wr_o,
   output logic        rd_o,
   output logic [2:0]  addr_o,
   output logic [7:0]  wdata_o,
   output logic        busy,
   output logic        done,
   output logic        err
);

   localparam logic [1:0] LAT_LAST  = 2'(RD_LAT - 1);
   localparam bit         DO_VERIFY = (VERIFY != 0);

   cfg_state_e  state, state_nxt;
   logic [15:0] div_q, div_nxt;
   logic [6:0]  fmt_q, fmt_nxt;
   logic [7:0]  fcr_q, fcr_nxt;
   logic [1:0]  cnt_q, cnt_nxt;
   bus_req_t    bus_nxt;
   logic        busy_nxt, done_nxt, err_nxt;
   logic        chk_last;
   logic [7:0]  chk_exp;
   logic [7:0]  lcr_dlab;

   // State, captured configuration and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state   <= ST_IDLE;
         div_q   <= 16'h0000;
         fmt_q   <= 7'h00;
         fcr_q   <= 8'h00;
         cnt_q   <= 2'd0;
         wr_o    <= 1'b0;
         rd_o    <= 1'b0;
         addr_o  <= 3'd0;
         wdata_o <= 8'h00;
         busy    <= 1'b0;
         done    <= 1'b0;
         err     <= 1'b0;
      end else begin
         state   <= state_nxt;
         div_q   <= div_nxt;
         fmt_q   <= fmt_nxt;
         fcr_q   <= fcr_nxt;
         cnt_q   <= cnt_nxt;
         wr_o    <= bus_nxt.wr;
         rd_o    <= bus_nxt.rd;
         addr_o  <= bus_nxt.addr;
         wdata_o <= bus_nxt.wdata;
         busy    <= busy_nxt;
         done    <= done_nxt;
         err     <= err_nxt;
      end
   end

   // Next state, then the bus request decoded from the state being entered.
   always_comb begin
      state_nxt = state;
      div_nxt   = div_q;
      fmt_nxt   = fmt_q;
      fcr_nxt   = fcr_q;
      cnt_nxt   = cnt_q;
      err_nxt   = err;
      chk_last  = (cnt_q == LAT_LAST);
      chk_exp   = 8'h00;
      bus_nxt   = '0;
      busy_nxt  = 1'b0;
      done_nxt  = 1'b0;
      lcr_dlab  = 8'h00;

      case (state)
         ST_IDLE: begin
            if (start) begin
               state_nxt = ST_WR_LCR_D;
               div_nxt   = divisor;
               fmt_nxt   = lcr_fmt;
               fcr_nxt   = fcr_val;
               err_nxt   = 1'b0;
            end
         end
         ST_WR_LCR_D: state_nxt = ST_WR_DLL;
         ST_WR_DLL:   state_nxt = ST_WR_DLM;
         ST_WR_DLM:   state_nxt = DO_VERIFY ? ST_RD_DLL : ST_WR_LCR;
         ST_RD_DLL: begin
            state_nxt = ST_CHK_DLL;
            cnt_nxt   = 2'd0;
         end
         ST_CHK_DLL: begin
            chk_exp = div_q[7:0];
            if (chk_last) begin
               state_nxt = ST_RD_DLM;
               if (rdata_i != chk_exp) err_nxt = 1'b1;
            end else begin
               cnt_nxt = cnt_q + 2'd1;
            end
         end
         ST_RD_DLM: begin
            state_nxt = ST_CHK_DLM;
            cnt_nxt   = 2'd0;
         end
         ST_CHK_DLM: begin
            chk_exp = div_q[15:8];
            if (chk_last) begin
               state_nxt = ST_WR_LCR;
               if (rdata_i != chk_exp) err_nxt = 1'b1;
            end else begin
               cnt_nxt = cnt_q + 2'd1;
            end
         end
         ST_WR_LCR:   state_nxt = ST_WR_FCR;
         ST_WR_FCR:   state_nxt = DO_VERIFY ? ST_RD_LCR : ST_DONE;
         ST_RD_LCR: begin
            state_nxt = ST_CHK_LCR;
            cnt_nxt   = 2'd0;
         end
         ST_CHK_LCR: begin
            chk_exp = {1'b0, fmt_q};
            if (chk_last) begin
               state_nxt = ST_DONE;
               if (rdata_i != chk_exp) err_nxt = 1'b1;
            end else begin
               cnt_nxt = cnt_q + 2'd1;
            end
         end
         ST_DONE:     state_nxt = ST_IDLE;
         default:     state_nxt = ST_IDLE;
      endcase

      // Outputs are registered, so decode from the state of the coming cycle.
      lcr_dlab               = {1'b0, fmt_nxt};
      lcr_dlab[LCR_DLAB_BIT] = 1'b1;
      busy_nxt               = (state_nxt != ST_IDLE);
      done_nxt               = (state_nxt == ST_DONE);

      case (state_nxt)
         ST_WR_LCR_D: bus_nxt = bus_write(ADDR_LCR, lcr_dlab);
         ST_WR_DLL:   bus_nxt = bus_write(ADDR_DLL_THR, div_nxt[7:0]);
         ST_WR_DLM:   bus_nxt = bus_write(ADDR_DLM_IER, div_nxt[15:8]);
         ST_RD_DLL:   bus_nxt = bus_read(ADDR_DLL_THR);
         ST_RD_DLM:   bus_nxt = bus_read(ADDR_DLM_IER);
         ST_WR_LCR:   bus_nxt = bus_write(ADDR_LCR, {1'b0, fmt_nxt});
         ST_WR_FCR:   bus_nxt = bus_write(ADDR_FCR, fcr_nxt);
         ST_RD_LCR:   bus_nxt = bus_read(ADDR_LCR);
         default:     bus_nxt = '0;
      endcase
   end

endmodule
